// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed common-anode 7-segment scanner with tear-free load, hex decode, zero blanking, dead time and PWM dimming
// Inputs:  clk_i, rst_i (async, active-low), bcd_i (nibble i = digit i, digit 0 rightmost), dp_i,
//          load_i (captures bcd_i/dp_i into the shadow), blank_lz_i, bright_i (duty, all-ones = full on)
// Outputs: anodo_o (active-low digit enables), catodo_o (g..a, active-low), dp_o (active-low),
//          frame_o (one-cycle pulse after each full scan)
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DISPLAY_REFRESH = 27000,
  parameter int BLANK_CYCLES = 64,
  parameter int HEX_MODE = 0,
  parameter int BRIGHT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic [NUM_DIGITS-1:0] dp_i,
  input  logic load_i,
  input  logic blank_lz_i,
  input  logic [BRIGHT_W-1:0] bright_i,
  output logic [NUM_DIGITS-1:0] anodo_o,
  output logic [6:0] catodo_o,
  output logic dp_o,
  output logic frame_o
);
  localparam int CW = $clog2(DISPLAY_REFRESH);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);
  logic [CW-1:0] c;
  logic [DW-1:0] d;
  logic [4*NUM_DIGITS-1:0] sh_bcd, act_bcd;
  logic [NUM_DIGITS-1:0] sh_dp, act_dp;
  logic [31:0] cc;
  logic wrap, boundary, lit, lz_blank;
  logic [3:0] nib;
  logic [6:0] seg;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'ha: p = 7'b0001000;
      4'hb: p = 7'b0000011;
      4'hc: p = 7'b1000110;
      4'hd: p = 7'b0100001;
      4'he: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return (HEX_MODE == 0 && n > 4'd9) ? 7'h7f : p;
  endfunction

  assign cc = 32'(c);
  assign wrap = c == CW'(DISPLAY_REFRESH - 1);
  assign boundary = wrap && d == DW'(NUM_DIGITS - 1);
  // dead time first, then PWM on the low BRIGHT_W bits of the slot counter
  assign lit = cc >= 32'(BLANK_CYCLES) &&
               (&bright_i || (cc & ((32'd1 << BRIGHT_W) - 32'd1)) < 32'(bright_i));
  assign nib = act_bcd[4*d +: 4];
  // this digit and every higher digit are zero; digit 0 always shows
  assign lz_blank = blank_lz_i && d != '0 && (act_bcd >> (4*d)) == '0;
  assign seg = lz_blank ? 7'h7f : dec(nib);

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      c <= '0;
      d <= '0;
      sh_bcd <= '0;
      sh_dp <= '0;
      act_bcd <= '0;
      act_dp <= '0;
      anodo_o <= '1;
      catodo_o <= 7'h7f;
      dp_o <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      c <= wrap ? '0 : c + 1'b1;
      if (wrap) d <= d == DW'(NUM_DIGITS - 1) ? '0 : d + 1'b1;
      if (load_i) begin
        sh_bcd <= bcd_i;
        sh_dp <= dp_i;
      end
      // non-blocking: a load on the boundary edge reaches the display one frame later
      if (boundary) begin
        act_bcd <= sh_bcd;
        act_dp <= sh_dp;
      end
      frame_o <= boundary;
      anodo_o <= lit ? ~(ONE << d) : '1;
      catodo_o <= lit ? seg : 7'h7f;
      dp_o <= lit ? ~act_dp[d] : 1'b1;
    end
endmodule
